// File: rtl/sat_clamp_pipe.sv
// Two-stage lane-parallel rounding shift followed by saturating clamp, with a
// saturating count of output beats that had any lane clamped.
module sat_clamp_pipe #(
    parameter int LANES      = 4,
    parameter int IN_W       = 32,
    parameter int OUT_W      = 8,
    parameter int SIGNED_OUT = 0,
    parameter int SHIFT      = 0,
    parameter int CNT_W      = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [LANES*IN_W-1:0]  s_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [LANES*OUT_W-1:0] m_data,
    output logic [LANES-1:0]       m_sat,
    output logic [CNT_W-1:0]       sat_count,
    input  logic                   clr_count
);

    // One extra bit so that rounding the most positive input cannot overflow.
    localparam int TW    = IN_W + 1;
    localparam int MAX_I = (SIGNED_OUT != 0) ? (1 << (OUT_W - 1)) - 1 : (1 << OUT_W) - 1;
    localparam int MIN_I = (SIGNED_OUT != 0) ? -(1 << (OUT_W - 1)) : 0;
    localparam logic signed [TW-1:0] MAX_V = TW'(MAX_I);
    localparam logic signed [TW-1:0] MIN_V = TW'(MIN_I);
    localparam logic signed [TW-1:0] RND   = TW'((1 << SHIFT) >> 1);

    function automatic logic signed [TW-1:0] round_shift(input logic signed [IN_W-1:0] x);
        logic signed [TW-1:0] xe;
        xe = TW'(x);
        if (SHIFT == 0) return xe;
        return (xe + RND) >>> SHIFT;
    endfunction

    // Returns {saturated, value}; hitting MIN or MAX exactly is not a saturation.
    function automatic logic [OUT_W:0] clamp(input logic signed [TW-1:0] t);
        if (t < MIN_V) return {1'b1, MIN_V[OUT_W-1:0]};
        if (t > MAX_V) return {1'b1, MAX_V[OUT_W-1:0]};
        return {1'b0, t[OUT_W-1:0]};
    endfunction

    logic                   v1;
    logic [LANES*TW-1:0]    d1;
    logic [LANES*TW-1:0]    d1_next;
    logic [LANES*OUT_W-1:0] d2_next;
    logic [LANES-1:0]       sat_next;
    logic                   adv1;
    logic                   adv2;

    // Handshake: a beat moves on a channel at a rising edge where valid and
    // ready are both high. A stage loads when it is empty or its consumer takes
    // its beat this cycle, so s_ready depends only on state and m_ready, and
    // m_valid is purely registered.
    assign adv2    = !m_valid || m_ready;
    assign adv1    = !v1 || adv2;
    assign s_ready = adv1;

    always_comb begin
        d1_next  = '0;
        d2_next  = '0;
        sat_next = '0;
        for (int i = 0; i < LANES; i++) begin
            d1_next[i*TW +: TW] = round_shift(s_data[i*IN_W +: IN_W]);
            {sat_next[i], d2_next[i*OUT_W +: OUT_W]} = clamp(d1[i*TW +: TW]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1        <= 1'b0;
            d1        <= '0;
            m_valid   <= 1'b0;
            m_data    <= '0;
            m_sat     <= '0;
            sat_count <= '0;
        end else begin
            if (adv1) begin
                v1 <= s_valid;
                if (s_valid) d1 <= d1_next;
            end
            if (adv2) begin
                m_valid <= v1;
                if (v1) begin
                    m_data <= d2_next;
                    m_sat  <= sat_next;
                end
            end
            if (clr_count) begin
                sat_count <= '0;
            end else if (m_valid && m_ready && (|m_sat) && (sat_count != {CNT_W{1'b1}})) begin
                sat_count <= sat_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_sat_clamp_pipe.sv
// Bench for sat_clamp_pipe: four parameterisations share one stimulus stream;
// a table of known vectors plus a model-driven scoreboard check all outputs.
module tb_sat_clamp_pipe;

    logic         clk = 1'b0;
    logic         rst;
    logic         s_valid;
    logic [127:0] s_data;
    logic         m_ready;
    logic         clr_count;

    logic        sr_def, mv_def, sr_sgn, mv_sgn, sr_shf, mv_shf, sr_cnt, mv_cnt;
    logic [31:0] md_def, md_sgn, md_shf, md_cnt;
    logic [3:0]  ms_def, ms_sgn, ms_shf, ms_cnt;
    logic [15:0] sc_def, sc_sgn, sc_shf;
    logic [1:0]  sc_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [35:0] exp_def_q[$];
    logic [35:0] exp_sgn_q[$];
    logic [35:0] exp_shf_q[$];
    logic [15:0] ecnt_def;
    logic [1:0]  ecnt2;
    bit          stall_prev;
    logic [35:0] held;

    always #5 clk = ~clk;

    sat_clamp_pipe u_def (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(sr_def), .s_data(s_data),
        .m_valid(mv_def), .m_ready(m_ready), .m_data(md_def), .m_sat(ms_def),
        .sat_count(sc_def), .clr_count(clr_count)
    );
    sat_clamp_pipe #(.SIGNED_OUT(1)) u_sgn (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(sr_sgn), .s_data(s_data),
        .m_valid(mv_sgn), .m_ready(m_ready), .m_data(md_sgn), .m_sat(ms_sgn),
        .sat_count(sc_sgn), .clr_count(clr_count)
    );
    sat_clamp_pipe #(.SHIFT(2)) u_shf (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(sr_shf), .s_data(s_data),
        .m_valid(mv_shf), .m_ready(m_ready), .m_data(md_shf), .m_sat(ms_shf),
        .sat_count(sc_shf), .clr_count(clr_count)
    );
    sat_clamp_pipe #(.CNT_W(2)) u_cnt (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(sr_cnt), .s_data(s_data),
        .m_valid(mv_cnt), .m_ready(m_ready), .m_data(md_cnt), .m_sat(ms_cnt),
        .sat_count(sc_cnt), .clr_count(clr_count)
    );

    function automatic void chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endfunction

    // Reference: widen to 64 bits, round-half-up shift, then clamp to 8 bits.
    function automatic logic [35:0] model_beat(input logic [127:0] din, input bit sgn, input int sh);
        logic [35:0] r;
        longint v, mn, mx;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            v = longint'($signed(din[i*32 +: 32]));
            if (sh > 0) v = (v + (longint'(1) <<< (sh - 1))) >>> sh;
            mn = sgn ? -128 : 0;
            mx = sgn ? 127 : 255;
            if (v < mn) begin
                r[32+i] = 1'b1;
                r[i*8 +: 8] = mn[7:0];
            end else if (v > mx) begin
                r[32+i] = 1'b1;
                r[i*8 +: 8] = mx[7:0];
            end else begin
                r[i*8 +: 8] = v[7:0];
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] p32(input logic [31:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    function automatic logic [31:0] p8(input logic [7:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    function automatic logic [127:0] rand_beat();
        logic [127:0] r;
        logic [31:0]  l;
        for (int i = 0; i < 4; i++) begin
            case ($urandom_range(0, 3))
                0: l = $urandom;
                1: l = 32'($urandom_range(0, 800)) - 32'd400;
                2: l = ($urandom_range(0, 1) != 0) ? 32'h7fffffff : 32'h80000000;
                default: l = 32'($urandom_range(0, 300));
            endcase
            r[i*32 +: 32] = l;
        end
        return r;
    endfunction

    // Scoreboard: push on s-side transfer, pop on m-side transfer; the next
    // rising edge performs what is sampled here.
    always @(negedge clk) begin
        logic [35:0] e;
        bit any_sat;
        if (rst) begin
            exp_def_q.delete();
            exp_sgn_q.delete();
            exp_shf_q.delete();
            ecnt_def   = '0;
            ecnt2      = '0;
            stall_prev = 0;
        end else begin
            chk("s_ready", 64'(sr_def), 64'(!(exp_def_q.size() == 2 && !m_ready)));
            chk("cnt_def", 64'(sc_def), 64'(ecnt_def));
            chk("cnt_w2", 64'(sc_cnt), 64'(ecnt2));
            if (stall_prev) begin
                chk("stall_valid", 64'(mv_def), 64'(1));
                chk("stall_hold", 64'({ms_def, md_def}), 64'(held));
            end
            any_sat = 0;
            if (mv_def && m_ready) begin
                n_cmp++;
                if (exp_def_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL def_extra_beat: got %0h expected none", {ms_def, md_def});
                end else begin
                    e = exp_def_q.pop_front();
                    any_sat = |e[35:32];
                    chk("def_beat", 64'({ms_def, md_def}), 64'(e));
                end
            end
            if (mv_sgn && m_ready) begin
                n_cmp++;
                if (exp_sgn_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sgn_extra_beat: got %0h expected none", {ms_sgn, md_sgn});
                end else begin
                    e = exp_sgn_q.pop_front();
                    chk("sgn_beat", 64'({ms_sgn, md_sgn}), 64'(e));
                end
            end
            if (mv_shf && m_ready) begin
                n_cmp++;
                if (exp_shf_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL shf_extra_beat: got %0h expected none", {ms_shf, md_shf});
                end else begin
                    e = exp_shf_q.pop_front();
                    chk("shf_beat", 64'({ms_shf, md_shf}), 64'(e));
                end
            end
            if (clr_count) begin
                ecnt_def = '0;
                ecnt2    = '0;
            end else if (any_sat) begin
                if (ecnt_def != 16'hffff) ecnt_def = ecnt_def + 16'd1;
                if (ecnt2 != 2'd3) ecnt2 = ecnt2 + 2'd1;
            end
            if (s_valid && sr_def) begin
                exp_def_q.push_back(model_beat(s_data, 0, 0));
                exp_sgn_q.push_back(model_beat(s_data, 1, 0));
                exp_shf_q.push_back(model_beat(s_data, 0, 2));
            end
            stall_prev = mv_def && !m_ready;
            held       = {ms_def, md_def};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        m_ready = 1'b1;
        for (int k = 0; k < 30 && exp_def_q.size() != 0; k++) tick();
        tick();
        chk("drain_empty", 64'(exp_def_q.size()), 64'(0));
    endtask

    // mode 0: m_ready cycles 1,0,0,1 with s_valid always high; mode 1: random.
    task automatic run_stream(input int n, input int mode);
        int sent = 0;
        int cyc  = 0;
        bit acc;
        s_valid = 1'b0;
        while (sent < n && cyc < 2000) begin
            m_ready = (mode == 0) ? (cyc % 4 == 0 || cyc % 4 == 3) : ($urandom_range(0, 2) != 0);
            if (!s_valid) begin
                s_valid = (mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
                if (s_valid) s_data = rand_beat();
            end
            @(negedge clk);
            acc = s_valid && sr_def;
            tick();
            cyc++;
            if (acc) begin
                sent++;
                s_valid = 1'b0;
            end
        end
        s_valid = 1'b0;
        chk("stream_sent", 64'(sent), 64'(n));
        drain();
    endtask

    typedef struct {
        logic [127:0] din;
        logic [31:0]  d_def;
        logic [3:0]   s_def;
        logic [31:0]  d_sgn;
        logic [3:0]   s_sgn;
        logic [31:0]  d_shf;
        logic [3:0]   s_shf;
    } vec_t;

    vec_t tbl[6];
    logic [1:0] cnt_seq[6];

    initial begin
        tbl[0] = '{p32(-5, 0, 255, 300),
                   p8(8'h00, 8'h00, 8'hFF, 8'hFF), 4'b1001,
                   p8(8'hFB, 8'h00, 8'h7F, 8'h7F), 4'b1100,
                   p8(8'h00, 8'h00, 8'h40, 8'h4B), 4'b0001};
        tbl[1] = '{p32(-200, -128, 127, 128),
                   p8(8'h00, 8'h00, 8'h7F, 8'h80), 4'b0011,
                   p8(8'h80, 8'h80, 8'h7F, 8'h7F), 4'b1001,
                   p8(8'h00, 8'h00, 8'h20, 8'h20), 4'b0011};
        tbl[2] = '{p32(6, -6, 32'h7fffffff, 32'h80000000),
                   p8(8'h06, 8'h00, 8'hFF, 8'h00), 4'b1110,
                   p8(8'h06, 8'hFA, 8'h7F, 8'h80), 4'b1100,
                   p8(8'h02, 8'h00, 8'hFF, 8'h00), 4'b1110};
        tbl[3] = '{p32(0, 255, 256, -1),
                   p8(8'h00, 8'hFF, 8'hFF, 8'h00), 4'b1100,
                   p8(8'h00, 8'h7F, 8'h7F, 8'hFF), 4'b0110,
                   p8(8'h00, 8'h40, 8'h40, 8'h00), 4'b0000};
        tbl[4] = '{p32(-128, 127, -129, 1),
                   p8(8'h00, 8'h7F, 8'h00, 8'h01), 4'b0101,
                   p8(8'h80, 8'h7F, 8'h80, 8'h01), 4'b0100,
                   p8(8'h00, 8'h20, 8'h00, 8'h00), 4'b0101};
        tbl[5] = '{p32(2, 1020, 1021, 1022),
                   p8(8'h02, 8'hFF, 8'hFF, 8'hFF), 4'b1110,
                   p8(8'h02, 8'h7F, 8'h7F, 8'h7F), 4'b1110,
                   p8(8'h01, 8'hFF, 8'hFF, 8'hFF), 4'b1000};
        cnt_seq = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd0};

        rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b1; clr_count = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_s_ready", 64'(sr_def), 64'(1));
        chk("rst_m_valid", 64'(mv_def), 64'(0));
        chk("rst_m_data", 64'(md_def), 64'(0));
        chk("rst_m_sat", 64'(ms_def), 64'(0));
        chk("rst_sat_count", 64'(sc_def), 64'(0));

        // Known vectors, one at a time, also checking the two-edge latency.
        foreach (tbl[v]) begin
            s_valid = 1'b1;
            s_data  = tbl[v].din;
            tick();
            s_valid = 1'b0;
            chk("lat_not_yet", 64'(mv_def), 64'(0));
            tick();
            chk("lat_valid", 64'(mv_def), 64'(1));
            chk("tbl_def", 64'({ms_def, md_def}), 64'({tbl[v].s_def, tbl[v].d_def}));
            chk("tbl_sgn", 64'({ms_sgn, md_sgn}), 64'({tbl[v].s_sgn, tbl[v].d_sgn}));
            chk("tbl_shf", 64'({ms_shf, md_shf}), 64'({tbl[v].s_shf, tbl[v].d_shf}));
            if (v == 0) chk("first_sat_count", 64'(sc_def), 64'(0));
            tick();
            if (v == 0) chk("after_sat_count", 64'(sc_def), 64'(1));
        end

        run_stream(8, 0);
        run_stream(80, 1);

        // Saturating 2-bit counter, then clear against a simultaneous saturating beat.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_ready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            s_valid   = (j < 6);
            s_data    = p32(300, 0, 0, 0);
            clr_count = (j == 7);
            tick();
            if (j >= 2) chk("cnt_seq", 64'(sc_cnt), 64'(cnt_seq[j-2]));
        end
        s_valid = 1'b0;
        clr_count = 1'b0;
        drain();

        // Reset with both stages full discards everything in flight.
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_data  = p32(-7, 400, 9, 3);
        tick();
        s_data  = p32(1000, 1, 2, 3);
        tick();
        chk("full_s_ready", 64'(sr_def), 64'(0));
        rst = 1'b1;
        tick();
        chk("midrst_m_valid", 64'(mv_def), 64'(0));
        chk("midrst_count", 64'(sc_def), 64'(0));
        chk("midrst_m_data", 64'(md_def), 64'(0));
        rst = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("no_stale_beat", 64'(mv_def), 64'(0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_cmp++;
        n_fail++;
        $display("FAIL global_timeout: got running expected finished");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
